// File: rtl/elevator_ctrl.sv
// Single-car elevator scheduler: latches floor calls, serves them with a SCAN
// (keep-direction) policy, and times the travel and door-open phases.
module elevator_ctrl #(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [3:0]            floor_bcd,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  dir_up,
  output logic                  dir_down,
  output logic                  busy
);

  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);
  localparam logic [3:0]    TOP_FLOOR   = 4'(NUM_FLOORS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              floor_q, floor_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    last_up_q, last_up_d;

  logic [NUM_FLOORS-1:0]   req;
  logic [NUM_FLOORS-1:0]   clear_mask;
  logic                    idle_above, idle_below;
  logic                    req_above, req_below;

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] v, input logic [3:0] f);
    any_above = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (v[i] && (4'(i) > f)) any_above = 1'b1;
    end
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] v, input logic [3:0] f);
    any_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (v[i] && (4'(i) < f)) any_below = 1'b1;
    end
  endfunction

  function automatic logic bit_at(input logic [NUM_FLOORS-1:0] v, input logic [3:0] f);
    bit_at = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (4'(i) == f) bit_at = v[i];
    end
  endfunction

  function automatic logic [NUM_FLOORS-1:0] onehot(input logic [3:0] f);
    onehot = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (4'(i) == f) onehot[i] = 1'b1;
    end
  endfunction

  always_comb begin
    req        = pending_q | call_req;
    idle_above = any_above(pending_q, floor_q);
    idle_below = any_below(pending_q, floor_q);
    req_above  = any_above(req, floor_q);
    req_below  = any_below(req, floor_q);

    state_d    = state_q;
    floor_d    = floor_q;
    timer_d    = timer_q + 1'b1;
    last_up_d  = last_up_q;
    clear_mask = '0;

    case (state_q)
      IDLE: begin
        // IDLE decides on latched calls only, so a call leaves IDLE one edge after it is latched.
        timer_d = '0;
        if (bit_at(pending_q, floor_q))     state_d = DOOR;
        else if (idle_above && idle_below)  state_d = last_up_q ? MOVE_UP : MOVE_DOWN;
        else if (idle_above)                state_d = MOVE_UP;
        else if (idle_below)                state_d = MOVE_DOWN;
      end

      MOVE_UP: begin
        if (floor_q >= TOP_FLOOR) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == TRAVEL_LAST) begin
          floor_d   = floor_q + 4'd1;
          timer_d   = '0;
          last_up_d = 1'b1;
          if (bit_at(req, floor_d))          state_d = DOOR;
          else if (!any_above(req, floor_d)) state_d = IDLE;
        end
      end

      MOVE_DOWN: begin
        if (floor_q == 4'd0) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == TRAVEL_LAST) begin
          floor_d   = floor_q - 4'd1;
          timer_d   = '0;
          last_up_d = 1'b0;
          if (bit_at(req, floor_d))          state_d = DOOR;
          else if (!any_below(req, floor_d)) state_d = IDLE;
        end
      end

      DOOR: begin
        if (bit_at(call_req, floor_q)) begin
          timer_d = '0;
        end else if (timer_q == DOOR_LAST) begin
          timer_d = '0;
          if (last_up_q ? req_above : req_below)      state_d = last_up_q ? MOVE_UP : MOVE_DOWN;
          else if (last_up_q ? req_below : req_above) state_d = last_up_q ? MOVE_DOWN : MOVE_UP;
          else                                        state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // The open floor's call is dropped on the entry edge and every door edge.
    if ((state_d == DOOR) || (state_q == DOOR)) clear_mask = onehot(floor_d);
    pending_d = req & ~clear_mask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      floor_q   <= 4'd0;
      pending_q <= '0;
      timer_q   <= '0;
      last_up_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      last_up_q <= last_up_d;
    end
  end

  assign floor_bcd = floor_q;
  assign pending   = pending_q;
  assign door_open = (state_q == DOOR);
  assign dir_up    = (state_q == MOVE_UP);
  assign dir_down  = (state_q == MOVE_DOWN);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: a table of {call pulse, edges to wait, expected outputs}
// rows run through a scoreboard queue, plus hand-written reset sequences.
module tb_elevator_ctrl;

  localparam int NF = 8;

  localparam logic [1:0] ST_I  = 2'd0;
  localparam logic [1:0] ST_UP = 2'd1;
  localparam logic [1:0] ST_DN = 2'd2;
  localparam logic [1:0] ST_D  = 2'd3;

  logic          clk;
  logic          reset_n;
  logic [NF-1:0] call_req;
  logic [3:0]    floor_bcd;
  logic [NF-1:0] pending;
  logic          door_open;
  logic          dir_up;
  logic          dir_down;
  logic          busy;

  elevator_ctrl #(
    .NUM_FLOORS   (NF),
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .call_req (call_req),
    .floor_bcd(floor_bcd),
    .pending  (pending),
    .door_open(door_open),
    .dir_up   (dir_up),
    .dir_down (dir_down),
    .busy     (busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NF-1:0] call;
    int            n;
    logic [15:0]   exp;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        s6_on    = 1'b0;
  logic        up_seen  = 1'b0;

  always @(negedge clk) begin
    if (s6_on && dir_up) up_seen = 1'b1;
  end

  function automatic logic [15:0] pack_exp(input logic [3:0] fl, input logic [NF-1:0] pend,
                                           input logic [1:0] st);
    return {fl, pend, st == ST_D, st == ST_UP, st == ST_DN, st != ST_I};
  endfunction

  function automatic void add(input logic [NF-1:0] call, input int n, input logic [3:0] fl,
                              input logic [NF-1:0] pend, input logic [1:0] st);
    vec_t v;
    v.call = call;
    v.n    = n;
    v.exp  = pack_exp(fl, pend, st);
    vecs.push_back(v);
  endfunction

  function automatic logic [15:0] obs();
    return {floor_bcd, pending, door_open, dir_up, dir_down, busy};
  endfunction

  task automatic cmp(input string name, input int idx, input logic [15:0] got,
                     input logic [15:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s[%0d]: got floor=%0d pend=%h door/up/down/busy=%b, expected floor=%0d pend=%h door/up/down/busy=%b",
                  name, idx, got[15:12], got[11:4], got[3:0], want[15:12], want[11:4], want[3:0]);
  endtask

  task automatic check_sb(input string name, input int idx);
    logic [15:0] want;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s[%0d]: scoreboard empty, got %h", name, idx, obs());
    end else begin
      want = exp_q.pop_front();
      cmp(name, idx, obs(), want);
    end
  endtask

  // driver: pulse the row's calls for one edge, then wait the remaining edges
  task automatic apply(input vec_t v, input int idx);
    call_req = v.call;
    exp_q.push_back(v.exp);
    for (int i = 0; i < v.n; i++) begin
      @(posedge clk);
      #1;
      call_req = '0;
    end
    check_sb("row", idx);
  endtask

  int s6_start, s6_end;

  initial begin
    reset_n  = 1'b0;
    call_req = '0;

    // single-floor service at floor 0
    add(8'h01, 1, 4'd0, 8'h01, ST_I);
    add(8'h00, 1, 4'd0, 8'h00, ST_D);
    add(8'h00, 1, 4'd0, 8'h00, ST_D);
    add(8'h00, 1, 4'd0, 8'h00, ST_D);
    add(8'h00, 1, 4'd0, 8'h00, ST_I);
    // travel 0 -> 3
    add(8'h08, 1, 4'd0, 8'h08, ST_I);
    add(8'h00, 1, 4'd0, 8'h08, ST_UP);
    add(8'h00, 3, 4'd0, 8'h08, ST_UP);
    add(8'h00, 1, 4'd1, 8'h08, ST_UP);
    add(8'h00, 4, 4'd2, 8'h08, ST_UP);
    add(8'h00, 4, 4'd3, 8'h00, ST_D);
    add(8'h00, 2, 4'd3, 8'h00, ST_D);
    add(8'h00, 1, 4'd3, 8'h00, ST_I);
    // SCAN: heading to 6, calls for 1 and 5 arrive -> order 5, 6, 1
    add(8'h40, 1, 4'd3, 8'h40, ST_I);
    add(8'h00, 1, 4'd3, 8'h40, ST_UP);
    add(8'h22, 1, 4'd3, 8'h62, ST_UP);
    add(8'h00, 3, 4'd4, 8'h62, ST_UP);
    add(8'h00, 4, 4'd5, 8'h42, ST_D);
    add(8'h00, 3, 4'd5, 8'h42, ST_UP);
    add(8'h00, 4, 4'd6, 8'h02, ST_D);
    add(8'h00, 3, 4'd6, 8'h02, ST_DN);
    add(8'h00, 8, 4'd4, 8'h02, ST_DN);
    add(8'h00, 12, 4'd1, 8'h00, ST_D);
    add(8'h00, 3, 4'd1, 8'h00, ST_I);
    // door held open by a call for the open floor
    add(8'h10, 1, 4'd1, 8'h10, ST_I);
    add(8'h00, 1, 4'd1, 8'h10, ST_UP);
    add(8'h00, 12, 4'd4, 8'h00, ST_D);
    for (int k = 0; k < 5; k++) add(8'h10, 1, 4'd4, 8'h00, ST_D);
    add(8'h00, 1, 4'd4, 8'h00, ST_D);
    add(8'h00, 1, 4'd4, 8'h00, ST_D);
    add(8'h00, 1, 4'd4, 8'h00, ST_I);
    // up to the top floor
    add(8'h80, 1, 4'd4, 8'h80, ST_I);
    add(8'h00, 1, 4'd4, 8'h80, ST_UP);
    add(8'h00, 12, 4'd7, 8'h00, ST_D);
    add(8'h00, 3, 4'd7, 8'h00, ST_I);
    // all calls from the top: serve 7, 6, ..., 0 going down only
    s6_start = vecs.size();
    add(8'hFF, 1, 4'd7, 8'hFF, ST_I);
    add(8'h00, 1, 4'd7, 8'h7F, ST_D);
    for (int f = 6; f >= 0; f--) begin
      add(8'h00, 3, 4'(f + 1), 8'((1 << (f + 1)) - 1), ST_DN);
      add(8'h00, 4, 4'(f), 8'((1 << f) - 1), ST_D);
    end
    add(8'h00, 3, 4'd0, 8'h00, ST_I);
    s6_end = vecs.size();
    // lead-in for the asynchronous reset sequence
    add(8'h08, 1, 4'd0, 8'h08, ST_I);
    add(8'h00, 1, 4'd0, 8'h08, ST_UP);
    add(8'h00, 8, 4'd2, 8'h08, ST_UP);
    add(8'h00, 2, 4'd2, 8'h08, ST_UP);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(16'h0000);
    check_sb("reset", 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(16'h0000);
    check_sb("post_reset", 0);

    for (int i = 0; i < vecs.size(); i++) begin
      s6_on = (i >= s6_start) && (i < s6_end);
      apply(vecs[i], i);
    end
    s6_on = 1'b0;
    cmp("no_up_from_top", 0, {15'd0, up_seen}, 16'h0000);

    // async reset mid-travel 2 -> 3, checked before any clock edge
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.push_back(16'h0000);
    check_sb("async_reset", 0);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(pack_exp(4'd0, 8'h00, ST_I));
    check_sb("after_reset", 0);
    begin
      vec_t v;
      v.call = 8'h04; v.n = 1; v.exp = pack_exp(4'd0, 8'h04, ST_I);
      apply(v, 100);
      v.call = 8'h00; v.n = 1; v.exp = pack_exp(4'd0, 8'h04, ST_UP);
      apply(v, 101);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
